// File: rtl/matrix_pkg.sv
// Shared types and address packing for the HUB75 scan engine.
// The pixel word layout matches the matrixsys on-chip RAM exports.
package matrix_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StShift,
    StLatch,
    StDisplay
  } scan_state_e;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned R_OFF  = 16;
  localparam int unsigned G_OFF  = 8;
  localparam int unsigned B_OFF  = 0;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic             sel,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {sel, row, col};
  endfunction

endpackage

// File: rtl/matrix_bcm_timer.sv
// Display-time counter for one BCM plane: loads BASE_TICKS<<plane and
// counts down while running; done marks the final display cycle.
module matrix_bcm_timer
  import matrix_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 4,
  parameter int unsigned BCM_BITS   = 8,
  parameter int unsigned PLANE_W    = $clog2(BCM_BITS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_run,
  input  logic [PLANE_W-1:0] i_plane,
  output logic               o_done
);

  localparam int unsigned CNT_W = $clog2(BASE_TICKS) + BCM_BITS;

  logic [CNT_W-1:0] r_cnt;

  // Loaded with width-1 so the count reaches zero on the last on-cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (CNT_W'(BASE_TICKS) << i_plane) - CNT_W'(1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/matrix_hub75_scan.sv
// HUB75 scan engine: reads both panel halves from the framebuffer RAMs and
// drives a 64x32 panel with binary-coded modulation, buffer chosen per frame.
module matrix_hub75_scan
  import matrix_pkg::*;
#(
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS_HALF  = 16,
  parameter int unsigned BCM_BITS   = 8,
  parameter int unsigned BASE_TICKS = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              buf_sel,
  output logic [ADDR_W-1:0] ram1_address,
  output logic [ADDR_W-1:0] ram2_address,
  output logic              ram1_clken,
  output logic              ram2_clken,
  output logic              ram1_chipselect,
  output logic              ram2_chipselect,
  output logic              ram1_write,
  output logic              ram2_write,
  output logic [31:0]       ram1_writedata,
  output logic [31:0]       ram2_writedata,
  output logic [3:0]        ram1_byteenable,
  output logic [3:0]        ram2_byteenable,
  input  logic [31:0]       ram1_readdata,
  input  logic [31:0]       ram2_readdata,
  output logic              panel_r1,
  output logic              panel_g1,
  output logic              panel_b1,
  output logic              panel_r2,
  output logic              panel_g2,
  output logic              panel_b2,
  output logic [3:0]        panel_row,
  output logic              panel_clk,
  output logic              panel_lat,
  output logic              panel_oe_n,
  output logic              frame_start
);

  localparam int unsigned PLANE_W = $clog2(BCM_BITS);

  scan_state_e        r_state;
  logic               r_cur_buf;
  logic [ROW_W-1:0]   r_row;
  logic [PLANE_W-1:0] r_plane;
  logic [COL_W-1:0]   r_col;
  logic               r_phase;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rd_en;
  logic               r_r1, r_g1, r_b1, r_r2, r_g2, r_b2;
  logic [3:0]         r_panel_row;
  logic               r_pclk;
  logic               r_lat;
  logic               r_oe_n;
  logic               r_frame_start;

  logic [BCM_BITS-1:0] w_r1, w_g1, w_b1, w_r2, w_g2, w_b2;
  logic                w_done;
  logic                w_plane_wrap;
  logic                w_row_wrap;
  logic                w_new_frame;
  logic [PLANE_W-1:0]  w_next_plane;
  logic [ROW_W-1:0]    w_next_row;
  logic                w_next_sel;
  logic                w_unused_hi;

  assign w_r1 = ram1_readdata[R_OFF +: BCM_BITS];
  assign w_g1 = ram1_readdata[G_OFF +: BCM_BITS];
  assign w_b1 = ram1_readdata[B_OFF +: BCM_BITS];
  assign w_r2 = ram2_readdata[R_OFF +: BCM_BITS];
  assign w_g2 = ram2_readdata[G_OFF +: BCM_BITS];
  assign w_b2 = ram2_readdata[B_OFF +: BCM_BITS];
  assign w_unused_hi = ^{ram1_readdata[31:24], ram2_readdata[31:24]};

  assign w_plane_wrap = (r_plane == PLANE_W'(BCM_BITS - 1));
  assign w_row_wrap   = (r_row == ROW_W'(ROWS_HALF - 1));
  assign w_new_frame  = w_plane_wrap && w_row_wrap;
  assign w_next_plane = w_plane_wrap ? '0 : r_plane + PLANE_W'(1);
  assign w_next_row   = !w_plane_wrap ? r_row : (w_row_wrap ? '0 : r_row + ROW_W'(1));
  assign w_next_sel   = w_new_frame ? buf_sel : r_cur_buf;

  matrix_bcm_timer #(
    .BASE_TICKS (BASE_TICKS),
    .BCM_BITS   (BCM_BITS),
    .PLANE_W    (PLANE_W)
  ) u_bcm_timer (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_load  (r_state == StLatch),
    .i_run   (r_state == StDisplay),
    .i_plane (r_plane),
    .o_done  (w_done)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state       <= StIdle;
      r_cur_buf     <= 1'b0;
      r_row         <= '0;
      r_plane       <= '0;
      r_col         <= '0;
      r_phase       <= 1'b0;
      r_addr        <= '0;
      r_rd_en       <= 1'b0;
      r_r1          <= 1'b0;
      r_g1          <= 1'b0;
      r_b1          <= 1'b0;
      r_r2          <= 1'b0;
      r_g2          <= 1'b0;
      r_b2          <= 1'b0;
      r_panel_row   <= '0;
      r_pclk        <= 1'b0;
      r_lat         <= 1'b0;
      r_oe_n        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_lat         <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_oe_n  <= 1'b1;
          r_rd_en <= 1'b0;
          r_pclk  <= 1'b0;
          if (enable) begin
            r_cur_buf     <= buf_sel;
            r_row         <= '0;
            r_plane       <= '0;
            r_frame_start <= 1'b1;
            r_addr        <= pack_addr(buf_sel, ROW_W'(0), COL_W'(0));
            r_rd_en       <= 1'b1;
            r_state       <= StPrefetch;
          end
        end
        StPrefetch: begin
          r_col   <= '0;
          r_phase <= 1'b0;
          r_pclk  <= 1'b0;
          r_addr  <= pack_addr(r_cur_buf, r_row, COL_W'(1));
          r_state <= StShift;
        end
        StShift: begin
          if (!r_phase) begin
            // readdata holds this column now; bits stay put through clk-high.
            r_r1    <= w_r1[r_plane];
            r_g1    <= w_g1[r_plane];
            r_b1    <= w_b1[r_plane];
            r_r2    <= w_r2[r_plane];
            r_g2    <= w_g2[r_plane];
            r_b2    <= w_b2[r_plane];
            r_pclk  <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_pclk  <= 1'b0;
            r_phase <= 1'b0;
            if (r_col == COL_W'(COLS - 1)) begin
              r_rd_en     <= 1'b0;
              r_lat       <= 1'b1;
              r_panel_row <= 4'(r_row);
              r_state     <= StLatch;
            end else begin
              r_col  <= r_col + COL_W'(1);
              r_addr <= pack_addr(r_cur_buf, r_row, r_col + COL_W'(2));
            end
          end
        end
        StLatch: begin
          r_oe_n  <= 1'b0;
          r_state <= StDisplay;
        end
        StDisplay: begin
          if (w_done) begin
            r_oe_n <= 1'b1;
            if (!enable) begin
              r_state <= StIdle;
            end else begin
              r_plane       <= w_next_plane;
              r_row         <= w_next_row;
              r_cur_buf     <= w_next_sel;
              r_frame_start <= w_new_frame;
              r_addr        <= pack_addr(w_next_sel, w_next_row, COL_W'(0));
              r_rd_en       <= 1'b1;
              r_state       <= StPrefetch;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ram1_address    = r_addr;
  assign ram2_address    = r_addr;
  assign ram1_clken      = r_rd_en;
  assign ram2_clken      = r_rd_en;
  assign ram1_chipselect = r_rd_en;
  assign ram2_chipselect = r_rd_en;
  assign ram1_write      = 1'b0;
  assign ram2_write      = 1'b0;
  assign ram1_writedata  = '0;
  assign ram2_writedata  = '0;
  assign ram1_byteenable = 4'hF;
  assign ram2_byteenable = 4'hF;

  assign panel_r1    = r_r1;
  assign panel_g1    = r_g1;
  assign panel_b1    = r_b1;
  assign panel_r2    = r_r2;
  assign panel_g2    = r_g2;
  assign panel_b2    = r_b2;
  assign panel_row   = r_panel_row;
  assign panel_clk   = r_pclk;
  assign panel_lat   = r_lat;
  assign panel_oe_n  = r_oe_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_hub75_scan.sv
// Directed bench for matrix_hub75_scan with a 1-cycle-latency RAM model;
// expected values are hand-computed from the scan timing.
module tb_matrix_hub75_scan;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic        buf_sel;
  logic [10:0] ram1_address, ram2_address;
  logic        ram1_clken, ram2_clken, ram1_chipselect, ram2_chipselect;
  logic        ram1_write, ram2_write;
  logic [31:0] ram1_writedata, ram2_writedata;
  logic [3:0]  ram1_byteenable, ram2_byteenable;
  logic [31:0] ram1_readdata, ram2_readdata;
  logic        panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
  logic [3:0]  panel_row;
  logic        panel_clk, panel_lat, panel_oe_n, frame_start;

  matrix_hub75_scan dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .enable          (enable),
    .buf_sel         (buf_sel),
    .ram1_address    (ram1_address),
    .ram2_address    (ram2_address),
    .ram1_clken      (ram1_clken),
    .ram2_clken      (ram2_clken),
    .ram1_chipselect (ram1_chipselect),
    .ram2_chipselect (ram2_chipselect),
    .ram1_write      (ram1_write),
    .ram2_write      (ram2_write),
    .ram1_writedata  (ram1_writedata),
    .ram2_writedata  (ram2_writedata),
    .ram1_byteenable (ram1_byteenable),
    .ram2_byteenable (ram2_byteenable),
    .ram1_readdata   (ram1_readdata),
    .ram2_readdata   (ram2_readdata),
    .panel_r1        (panel_r1),
    .panel_g1        (panel_g1),
    .panel_b1        (panel_b1),
    .panel_r2        (panel_r2),
    .panel_g2        (panel_g2),
    .panel_b2        (panel_b2),
    .panel_row       (panel_row),
    .panel_clk       (panel_clk),
    .panel_lat       (panel_lat),
    .panel_oe_n      (panel_oe_n),
    .frame_start     (frame_start)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc++;

  logic [31:0] mem1 [0:2047];
  logic [31:0] mem2 [0:2047];
  always @(posedge clk_clk) begin
    ram1_readdata <= mem1[ram1_address];
    ram2_readdata <= mem2[ram2_address];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row lines may only move during a blanked latch cycle, one row at a time.
  logic       seq_on = 1'b0;
  logic [3:0] prev_row = 4'd0;
  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1 && seq_on && panel_row !== prev_row) begin
      check("row_step", {panel_lat, panel_oe_n, panel_row}, {2'b11, 4'(prev_row + 4'd1)});
    end
    prev_row = panel_row;
  end

  int         t_fs0, cnt, width, bad;
  int         t_fall [9];
  int         w_meas [8];
  logic       found, prev_clk;
  logic [5:0] bits, b_first, b_second, b_last;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    mem1[0]  = 32'h00FF0000;  mem2[0]  = 32'h000000FF;
    mem1[1]  = 32'h0000FF00;  mem2[1]  = 32'h00FF00FF;
    mem1[63] = 32'h00000001;  mem2[63] = 32'h00010000;
    b_first = '0; b_second = '0; b_last = '0;

    reset_reset_n = 1'b0;
    enable        = 1'b0;
    buf_sel       = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("rst_oe_n", panel_oe_n, 1);
    check("rst_ctl", {panel_clk, panel_lat, frame_start, ram1_clken, ram1_chipselect}, 0);
    check("rst_addr", ram1_address, 0);
    check("rst_row", panel_row, 0);

    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);
    check("idle_wait", {ram1_clken, panel_oe_n, frame_start}, 3'b010);

    seq_on = 1'b1;
    enable = 1'b1;
    @(negedge clk_clk);
    t_fs0 = cyc;
    check("fs_first", frame_start, 1);
    check("prefetch_addr", ram1_address, 0);
    check("prefetch_rd", {ram1_clken, ram2_clken, ram1_chipselect, ram2_chipselect}, 4'hF);
    check("consts", {ram1_write, ram2_write, ram1_byteenable, ram2_byteenable}, {2'b00, 8'hFF});
    check("wdata", ram1_writedata | ram2_writedata, 0);

    // First row/plane 0 shift: count rising panel_clk until the latch.
    prev_clk = panel_clk;
    cnt      = 0;
    found    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_clk);
      if (i == 10) check("addr_pair", ram2_address, ram1_address);
      if (panel_clk && !prev_clk) begin
        cnt++;
        bits = {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2};
        if (cnt == 1)  b_first  = bits;
        if (cnt == 2)  b_second = bits;
        if (cnt == 64) b_last   = bits;
      end
      prev_clk = panel_clk;
      if (panel_lat) begin
        found = 1'b1;
        break;
      end
    end
    check("lat_seen", found, 1);
    check("clk_edges", cnt, 64);
    check("lat_blank", {panel_oe_n, panel_clk, ram1_clken}, 3'b100);
    check("lat_row0", panel_row, 0);
    check("bits_col0", b_first, 6'b100001);
    check("bits_col1", b_second, 6'b010101);
    check("bits_col63", b_last, 6'b001100);

    // BCM widths and plane periods (fall-to-fall), planes 0..7 of row 0.
    for (int b = 0; b < 9; b++) begin
      for (int k = 0; k < 700 && panel_oe_n !== 1'b0; k++) @(negedge clk_clk);
      t_fall[b] = cyc;
      if (b < 8) begin
        width = 0;
        while (panel_oe_n === 1'b0 && width < 1000) begin
          width++;
          @(negedge clk_clk);
        end
        w_meas[b] = width;
      end
    end
    for (int b = 0; b < 8; b++) begin
      check($sformatf("oe_width_p%0d", b), w_meas[b], 4 << b);
      check($sformatf("period_p%0d", b), t_fall[b+1] - t_fall[b], 130 + (4 << b));
    end

    // Mid-frame buffer request must wait for the next frame start.
    buf_sel = 1'b1;
    bad     = 0;
    found   = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk_clk);
      if (frame_start) begin
        found = 1'b1;
        break;
      end
      if (ram1_clken && ram1_address[10] !== 1'b0) bad++;
    end
    check("fs_second", found, 1);
    check("buf_hold", bad, 0);
    check("buf_flip", ram1_address[10], 1);
    check("frame_period", cyc - t_fs0, 32960);

    // Drop enable during the shift of row 5 plane 3 (after 43 latches).
    cnt = 0;
    for (int i = 0; i < 20000 && cnt < 43; i++) begin
      @(negedge clk_clk);
      if (panel_lat) cnt++;
    end
    check("lat_count", cnt, 43);
    for (int i = 0; i < 300 && panel_clk !== 1'b1; i++) @(negedge clk_clk);
    check("in_shift", panel_clk, 1);
    enable = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_clk);
      if (panel_lat) begin
        found = 1'b1;
        break;
      end
    end
    check("drop_lat", found, 1);
    check("drop_row", panel_row, 5);
    for (int k = 0; k < 10 && panel_oe_n !== 1'b0; k++) @(negedge clk_clk);
    width = 0;
    while (panel_oe_n === 1'b0 && width < 1000) begin
      width++;
      @(negedge clk_clk);
    end
    check("drop_width", width, 32);
    bad = 0;
    repeat (60) begin
      @(negedge clk_clk);
      if (!(panel_oe_n === 1'b1 && ram1_clken === 1'b0 && frame_start === 1'b0)) bad++;
    end
    check("idle_after_drop", bad, 0);

    seq_on = 1'b0;
    enable = 1'b1;
    @(negedge clk_clk);
    check("reen_fs", {frame_start, ram1_address}, {1'b1, 11'h400});
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_clk);
      if (panel_lat) begin
        found = 1'b1;
        break;
      end
    end
    check("reen_lat", found, 1);
    check("reen_row", panel_row, 0);

    // Asynchronous reset in the middle of a shift.
    for (int i = 0; i < 300 && panel_clk !== 1'b1; i++) @(negedge clk_clk);
    check("pre_rst_shift", {panel_clk, ram1_clken}, 2'b11);
    #2;
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    #1;
    check("rst_mid_ctl", {panel_oe_n, panel_clk, panel_lat, ram1_clken}, 4'b1000);
    check("rst_mid_addr", ram1_address, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (10) @(negedge clk_clk);
    check("rst_idle", {panel_oe_n, ram1_clken, frame_start, panel_clk}, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
